segment_scan_decoder: RTL and testbench

Receive-side counterpart of the four-digit seven-segment scan driver. Samples the multiplexed active-low anode/cathode lines and reconstructs the four displayed digits as BCD, with per-digit blank and invalid flags and a one-cycle frame-complete strobe. Used on-chip for display self-check and readback, and as the bench monitor for the display path in the clock/stopwatch design.

---
 rtl/seg_pkg.sv | 49 ++++
 rtl/seg_pattern_decode.sv | 31 +++
 rtl/segment_scan_decoder.sv | 171 +++++++++++++++++
 tb/tb_segment_scan_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan receive path.
// Patterns are active-low, bit6 = segment a ... bit0 = segment g.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef logic [1:0] digit_idx_t;

    // True only when exactly one digit enable is driven low.
    function automatic logic anode_single(input logic [3:0] anode);
        logic hit;
        hit = 1'b0;
        case (anode)
            AN_DIG0, AN_DIG1, AN_DIG2, AN_DIG3: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic digit_idx_t anode_index(input logic [3:0] anode);
        digit_idx_t idx;
        idx = 2'd0;
        case (anode)
            AN_DIG1: idx = 2'd1;
            AN_DIG2: idx = 2'd2;
            AN_DIG3: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to BCD decoder.
// Non-decimal, non-blank patterns report 4'hF with is_invalid set.
module seg_pattern_decode (
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       is_blank,
    output logic       is_invalid
);
    import seg_pkg::*;

    always_comb begin
        bcd        = BCD_INVALID;
        is_blank   = 1'b0;
        is_invalid = 1'b0;
        case (pattern)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/segment_scan_decoder.sv
// Reconstructs four BCD digits from multiplexed active-low anode/cathode lines.
// Optional blink detection is compiled in with SEG_BLINK_DETECT_EN.
module segment_scan_decoder #(
    parameter int SETTLE_CYCLES     = 4,
    parameter int BLINK_HOLD_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anode_in,
    input  logic [6:0] cathode_in,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] blank_mask,
    output logic [3:0] invalid_mask,
    output logic       frame_valid
`ifdef SEG_BLINK_DETECT_EN
    ,
    output logic [3:0] blink_mask
`endif
);
    import seg_pkg::*;

    // Counter saturates at SETTLE_CYCLES+1 so a long dwell captures only once.
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SETTLE_CYCLES + 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_settle_range
        $error("SETTLE_CYCLES must be within 1..255");
    end
    if (BLINK_HOLD_FRAMES < 1) begin : g_hold_range
        $error("BLINK_HOLD_FRAMES must be at least 1");
    end

    logic [10:0]      sync_ff1;
    logic [10:0]      sync_ff2;
    logic [10:0]      word_prev;
    logic [CNT_W-1:0] stable_cnt;
    logic             word_stable;
    logic             capture;

    logic [3:0]       dec_bcd;
    logic             dec_blank;
    logic             dec_invalid;
    digit_idx_t       cap_idx;

    logic [3:0][3:0]  digit_q;
    logic [3:0]       blank_q;
    logic [3:0]       invalid_q;
    logic [3:0]       seen_q;
    logic             frame_q;

    logic [3:0][3:0]  digit_next;
    logic [3:0]       blank_next;
    logic [3:0]       invalid_next;
    logic [3:0]       seen_next;
    logic             frame_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff1   <= '1;
            sync_ff2   <= '1;
            word_prev  <= '1;
            stable_cnt <= '0;
        end else begin
            sync_ff1  <= {anode_in, cathode_in};
            sync_ff2  <= sync_ff1;
            word_prev <= sync_ff2;
            if (!word_stable) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_SAT) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

    assign word_stable = (sync_ff2 == word_prev);
    assign capture     = word_stable && (stable_cnt == CNT_HIT) && anode_single(sync_ff2[10:7]);
    assign cap_idx     = anode_index(sync_ff2[10:7]);

    seg_pattern_decode u_decode (
        .pattern    (sync_ff2[6:0]),
        .bcd        (dec_bcd),
        .is_blank   (dec_blank),
        .is_invalid (dec_invalid)
    );

    always_comb begin
        digit_next   = digit_q;
        blank_next   = blank_q;
        invalid_next = invalid_q;
        seen_next    = seen_q;
        frame_next   = 1'b0;
        if (capture) begin
            // A blank capture keeps the last displayed value for readback.
            if (dec_blank) begin
                blank_next[cap_idx]   = 1'b1;
                invalid_next[cap_idx] = 1'b0;
            end else begin
                digit_next[cap_idx]   = dec_bcd;
                blank_next[cap_idx]   = 1'b0;
                invalid_next[cap_idx] = dec_invalid;
            end
            seen_next[cap_idx] = 1'b1;
            if (&seen_next) begin
                frame_next = 1'b1;
                seen_next  = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q   <= '0;
            blank_q   <= '0;
            invalid_q <= '0;
            seen_q    <= '0;
            frame_q   <= 1'b0;
        end else begin
            digit_q   <= digit_next;
            blank_q   <= blank_next;
            invalid_q <= invalid_next;
            seen_q    <= seen_next;
            frame_q   <= frame_next;
        end
    end

    assign digit3       = digit_q[3];
    assign digit2       = digit_q[2];
    assign digit1       = digit_q[1];
    assign digit0       = digit_q[0];
    assign blank_mask   = blank_q;
    assign invalid_mask = invalid_q;
    assign frame_valid  = frame_q;

`ifdef SEG_BLINK_DETECT_EN
    localparam int HOLD_W = $clog2(BLINK_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(BLINK_HOLD_FRAMES);

    logic [3:0]             blank_hist;
    logic [3:0]             blink_q;
    logic [3:0][HOLD_W-1:0] hold_cnt;

    // Per-digit down-counter: reloaded on each blank/non-blank change between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_hist <= '0;
            blink_q    <= '0;
            hold_cnt   <= '0;
        end else if (frame_next) begin
            blank_hist <= blank_next;
            for (int i = 0; i < 4; i++) begin
                if (blank_next[i] != blank_hist[i]) begin
                    blink_q[i]  <= 1'b1;
                    hold_cnt[i] <= HOLD_RELOAD;
                end else if (hold_cnt[i] != '0) begin
                    hold_cnt[i] <= hold_cnt[i] - HOLD_W'(1);
                    if (hold_cnt[i] == HOLD_W'(1)) begin
                        blink_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign blink_mask = blink_q;
`endif

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Randomized self-checking bench for segment_scan_decoder against a run-length based reference.
// Blink checks are included when SEG_BLINK_DETECT_EN is defined.
module tb_segment_scan_decoder;

    localparam int SETTLE = 4;
    localparam int HOLD   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] anode_in = 4'hF;
    logic [6:0] cathode_in = 7'h7F;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic [3:0] blank_mask, invalid_mask;
    logic       frame_valid;
    logic [3:0] blink_mask;

    segment_scan_decoder #(
        .SETTLE_CYCLES     (SETTLE),
        .BLINK_HOLD_FRAMES (HOLD)
    ) dut (
`ifdef SEG_BLINK_DETECT_EN
        .blink_mask   (blink_mask),
`endif
        .clk          (clk),
        .rst          (rst),
        .anode_in     (anode_in),
        .cathode_in   (cathode_in),
        .digit3       (digit3),
        .digit2       (digit2),
        .digit1       (digit1),
        .digit0       (digit0),
        .blank_mask   (blank_mask),
        .invalid_mask (invalid_mask),
        .frame_valid  (frame_valid)
    );

`ifndef SEG_BLINK_DETECT_EN
    assign blink_mask = 4'b0000;
`endif

    always #5 clk = ~clk;

    // Decimal glyphs indexed by value, active-low a..g.
    logic [6:0] dec_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    localparam logic [6:0] BLANK   = 7'b1111111;
    localparam logic [6:0] BAD_PAT = 7'b1110000;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int fv_count = 0;
    int last_fv_cyc = -1;

    // Reference state
    logic [3:0]  m_digit [4];
    logic [3:0]  m_blank, m_invalid, m_seen;
    logic        m_fv;
    logic [3:0]  m_blink, m_prev_blank;
    int          m_hold [4];
    logic [10:0] hist [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_digit[i] = 4'h0;
            m_hold[i]  = 0;
        end
        m_blank = 0; m_invalid = 0; m_seen = 0; m_fv = 0;
        m_blink = 0; m_prev_blank = 0;
        hist.delete();
        repeat (3) hist.push_back(11'h7FF);
    endfunction

    function automatic void model_frame();
        for (int i = 0; i < 4; i++) begin
            if (m_blank[i] != m_prev_blank[i]) begin
                m_blink[i] = 1'b1;
                m_hold[i]  = HOLD;
            end else if (m_hold[i] > 0) begin
                m_hold[i]--;
                if (m_hold[i] == 0) m_blink[i] = 1'b0;
            end
        end
        m_prev_blank = m_blank;
    endfunction

    function automatic void model_capture(input logic [10:0] w);
        int zeros = 0;
        int idx = 0;
        int v = -1;
        for (int i = 0; i < 4; i++) begin
            if (!w[7+i]) begin
                zeros++;
                idx = i;
            end
        end
        if (zeros != 1) return;
        for (int k = 0; k < 10; k++) if (w[6:0] == dec_tbl[k]) v = k;
        if (w[6:0] == BLANK) begin
            m_blank[idx]   = 1'b1;
            m_invalid[idx] = 1'b0;
        end else if (v >= 0) begin
            m_digit[idx]   = 4'(v);
            m_blank[idx]   = 1'b0;
            m_invalid[idx] = 1'b0;
        end else begin
            m_digit[idx]   = 4'hF;
            m_blank[idx]   = 1'b0;
            m_invalid[idx] = 1'b1;
        end
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
            m_fv   = 1'b1;
            m_seen = 0;
            model_frame();
        end
    endfunction

    // A word is captured two synchronizer edges late, once its run of identical samples reaches SETTLE+1.
    function automatic void model_step(input logic [10:0] w_in);
        int k = 0;
        bit open_run = 1'b1;
        logic [10:0] w;
        m_fv = 1'b0;
        hist.push_back(w_in);
        if (hist.size() > 64) void'(hist.pop_front());
        w = hist[hist.size()-3];
        for (int j = hist.size() - 3; j >= 0; j--) begin
            if (hist[j] == w) k++;
            else begin
                open_run = 1'b0;
                break;
            end
        end
        if (!open_run && k == SETTLE + 1) model_capture(w);
    endfunction

    task automatic tick(input logic [3:0] an, input logic [6:0] ca);
        anode_in   = an;
        cathode_in = ca;
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else     model_step({an, ca});
        @(negedge clk);
        if (frame_valid) begin
            fv_count++;
            last_fv_cyc = cyc;
        end
        check_val("digits", {digit3, digit2, digit1, digit0},
                  {m_digit[3], m_digit[2], m_digit[1], m_digit[0]});
        check_val("flags", {blank_mask, invalid_mask, frame_valid},
                  {m_blank, m_invalid, m_fv});
`ifdef SEG_BLINK_DETECT_EN
        check_val("blink", blink_mask, m_blink);
`endif
    endtask

    task automatic dwell(input int idx, input logic [6:0] ca, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << idx);
        repeat (n) tick(an, ca);
    endtask

    task automatic scan4(input logic [6:0] c3, input logic [6:0] c2, input logic [6:0] c1,
                         input logic [6:0] c0, input int n);
        dwell(3, c3, n);
        dwell(2, c2, n);
        dwell(1, c1, n);
        dwell(0, c0, n);
    endtask

    task automatic pulse_reset(input logic [3:0] an, input logic [6:0] ca);
        rst = 1'b1;
        model_reset();
        repeat (3) tick(an, ca);
        check_val("rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check_val("rst_masks", {blank_mask, invalid_mask, frame_valid}, 9'h000);
        rst = 1'b0;
    endtask

    initial begin
        int n_edge;
        int fc;
        int r;
        int n;
        logic [3:0] an;
        logic [6:0] ca;

        model_reset();
        pulse_reset(4'hF, BLANK);
        dwell(0, BLANK, 0);
        repeat (4) tick(4'hF, BLANK);

        // Basic frame and latency from the digit0 word to the strobe.
        fc = fv_count;
        dwell(3, dec_tbl[1], 16);
        dwell(2, dec_tbl[2], 16);
        dwell(1, dec_tbl[3], 16);
        n_edge = cyc + 1;
        dwell(0, dec_tbl[4], 16);
        check_val("frame_latency", last_fv_cyc - n_edge, SETTLE + 2);
        check_val("frame_count", fv_count - fc, 1);
        check_val("frame_digits", {digit3, digit2, digit1, digit0}, 16'h1234);

        // Blank keeps the old value, then an invalid pattern forces F.
        scan4(dec_tbl[1], dec_tbl[2], BLANK, dec_tbl[4], 16);
        check_val("blank_mask", blank_mask, 4'b0010);
        check_val("blank_hold", {digit3, digit2, digit1, digit0}, 16'h1234);
        dwell(1, BAD_PAT, 16);
        check_val("invalid_digit", {digit3, digit2, digit1, digit0}, 16'h12F4);
        check_val("invalid_mask", {blank_mask, invalid_mask}, 8'b0000_0010);

        // Short glitch mid-dwell, then multi-low and dark anodes.
        dwell(2, dec_tbl[5], 6);
        dwell(2, BAD_PAT, 2);
        dwell(2, dec_tbl[5], 10);
        repeat (16) tick(4'b0011, BAD_PAT);
        repeat (16) tick(4'b1111, dec_tbl[8]);
        check_val("glitch_digits", {digit3, digit2, digit1, digit0}, 16'h15F4);
        check_val("glitch_invalid", invalid_mask, 4'b0010);

        // Dwell too short to settle.
        fc = fv_count;
        repeat (3) scan4(dec_tbl[7], dec_tbl[8], dec_tbl[9], dec_tbl[0], 4);
        check_val("short_frames", fv_count - fc, 0);
        check_val("short_digits", {digit3, digit2, digit1, digit0}, 16'h15F4);
        repeat (8) tick(4'hF, BLANK);

        // Reset mid-frame discards partial progress.
        dwell(3, dec_tbl[7], 16);
        dwell(2, dec_tbl[8], 8);
        pulse_reset(4'b1011, dec_tbl[8]);
        fc = fv_count;
        dwell(3, dec_tbl[6], 16);
        dwell(2, dec_tbl[7], 16);
        dwell(1, dec_tbl[8], 16);
        check_val("post_rst_partial", fv_count - fc, 0);
        dwell(0, dec_tbl[9], 16);
        check_val("post_rst_frame", fv_count - fc, 1);
        check_val("post_rst_digits", {digit3, digit2, digit1, digit0}, 16'h6789);

        // Random scans, glitches and malformed anodes.
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       an = ~(4'b0001 << $urandom_range(0, 3));
            else if (r < 8)  an = 4'hF;
            else             an = 4'($urandom);
            r = $urandom_range(0, 19);
            if (r < 14)      ca = dec_tbl[$urandom_range(0, 9)];
            else if (r < 17) ca = BLANK;
            else             ca = 7'($urandom);
            n = $urandom_range(1, 20);
            if (n > 10 && $urandom_range(0, 3) == 0) begin
                repeat (3) tick(an, ca);
                repeat (2) tick(an, ca ^ 7'($urandom_range(1, 127)));
                repeat (n - 5) tick(an, ca);
            end else begin
                repeat (n) tick(an, ca);
            end
        end

`ifdef SEG_BLINK_DETECT_EN
        pulse_reset(4'hF, BLANK);
        for (int f = 0; f < 6; f++) begin
            scan4((f % 2 == 0) ? BLANK : dec_tbl[5], dec_tbl[1], dec_tbl[2], dec_tbl[3], 12);
        end
        check_val("blink_set", blink_mask[3], 1'b1);
        repeat (5) scan4(dec_tbl[5], dec_tbl[1], dec_tbl[2], dec_tbl[3], 12);
        check_val("blink_clear", blink_mask[3], 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
